fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one synchronous FIFO buffer among NUM_REQ producers.
//  Each producer uses a valid/ready handshake; the arbiter grants one producer at a time,
//  drives the FIFO write strobe and data, and never writes while the FIFO reports full.
//  Sits directly in front of the FIFO's Data_in / write_to_stack / stack_full pins.
// PARAMETERS
//  NUM_REQ    4   number of producers (2..16)
//  DATA_W     32  data width; equals FIFO stack_width
//  ID_W       2   grant id width; equals clog2(NUM_REQ)
//  BURST_LEN  4   max beats per grant when FIFO_ARB_BURST_EN is defined (1..255)
// PORTS
//  clk          in   1               clock
//  rst          in   1               async reset, active-high
//  req_valid    in   NUM_REQ         producer i has a word
//  req_data     in   NUM_REQ*DATA_W  producer i word at bits [i*DATA_W +: DATA_W]
//  req_ready    out  NUM_REQ         word of producer i accepted this cycle when valid&ready
//  fifo_full    in   1               FIFO stack_full
//  fifo_wr      out  1               FIFO write_to_stack
//  fifo_din     out  DATA_W          FIFO Data_in
//  grant_valid  out  1               a grant is held (state XFER)
//  grant_id     out  ID_W            index of granted producer
// BEHAVIOUR
//  - Reset: state=ARB, grant_id=0, rr_ptr=0, beat_cnt=0; outputs req_ready=0, fifo_wr=0,
//    fifo_din=0, grant_valid=0. Reset mid-burst aborts the grant; no word is written.
//  - States: ARB, XFER. Registered: state, grant_id, rr_ptr, beat_cnt.
//  - ARB: no ready asserted. If any req_valid: winner = first valid index scanning
//    rr_ptr, rr_ptr+1, ... mod NUM_REQ; next cycle state=XFER, grant_id=winner, beat_cnt=0.
//    Arbitration latency: 1 cycle from valid to grant.
//  - XFER: req_ready[grant_id] = !fifo_full; all other readies 0.
//    fifo_wr = req_valid[grant_id] & !fifo_full (combinational);
//    fifo_din = req_data[grant_id] when fifo_wr, else 0.
//  - Accepted beat increments beat_cnt. Leave XFER -> ARB (rr_ptr = grant_id+1 mod NUM_REQ) when:
//    beat limit reached on an accepted beat, or req_valid[grant_id]=0 in a cycle.
//  - fifo_full in XFER: stall, grant held, no write, beat_cnt unchanged.
//  - Simultaneous FIFO read while full: still no write (FIFO drops write when full).
//  - Producer must hold valid/data stable until accepted; deasserting valid releases grant.
//  - Sustained throughput with one busy producer: BURST_LEN beats per BURST_LEN+1 cycles.
// CONFIGURATION
//  - FIFO_ARB_BURST_EN defined: beat limit = BURST_LEN; beat_cnt is 8 bits.
//  - Not defined: beat limit = 1 (one word per grant, strict per-word round robin);
//    beat_cnt logic removed, BURST_LEN ignored.
// STRUCTURE
//  - Package fifo_arb_pkg: state encodings ST_ARB=1'b0, ST_XFER=1'b1; clog2 helper function.
//  - Sub-module rr_picker: combinational rotate-priority encoder
//    (req vector, rr_ptr -> winner id, any_valid); instantiated once.
//  - Top: FSM, grant/beat registers, ready decode, data mux.
// TESTING
//  - Reset: assert rst with req_valid=4'b1111 -> req_ready=0, fifo_wr=0, grant_valid=0 throughout.
//  - Fairness: all 4 valid, fifo_full=0, burst off -> grant order 0,1,2,3,0; one write per 2 cycles.
//  - Burst (FIFO_ARB_BURST_EN, BURST_LEN=4): req 1 holds valid for 10 words
//    -> 4 writes, 1 ARB cycle, 4 writes, 1 ARB cycle, 2 writes.
//  - Full stall: fifo_full=1 for 3 cycles mid-burst -> fifo_wr=0, req_ready=0, grant_id stable;
//    resumes with same data.
//  - Early release: granted producer drops valid after 2 beats -> ARB next cycle,
//    rr_ptr=grant_id+1.
//  - Scoreboard vs FIFO model: 4 producers with random valid and random full, 1000 cycles
//    -> no lost/duplicated/reordered words per producer; no write while full.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Holds the FSM state encoding and an elaboration-time clog2 used to size grant ids.
package fifo_arb_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Ceiling log2, evaluated at elaboration to size index fields.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder.
// Scans req starting at rr_ptr and wrapping modulo NUM_REQ; the first set bit wins.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid index overwrites last and wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter sharing one FIFO among NUM_REQ producers.
// One producer holds the grant at a time; words move only when the FIFO is not full.
// Build option FIFO_ARB_BURST_EN: when defined a grant may carry up to BURST_LEN beats,
// otherwise every grant carries a single word (strict per-word round robin).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 2,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1 || BURST_LEN > 255 ||
        ID_W != clog2(NUM_REQ)) begin : g_bad_param
        $error("fifo_wr_arbiter: illegal parameter combination");
    end

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     next_ptr;
    logic                any_valid;
    logic                sel_valid;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                last_beat;

`ifdef FIFO_ARB_BURST_EN
    logic [7:0]          beat_cnt_q, beat_cnt_d;

    assign last_beat = (beat_cnt_q == 8'(BURST_LEN - 1));
`else
    assign last_beat = 1'b1;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (pick_id),
        .any_valid (any_valid)
    );

    // Route the granted producer's valid/data and build its one-hot ready slot.
    always_comb begin
        sel_valid    = 1'b0;
        sel_data     = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_valid       = req_valid[i];
                sel_data        = req_data[i*DATA_W +: DATA_W];
                grant_onehot[i] = 1'b1;
            end
        end
        next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
    end

    // FSM next state and handshake outputs; FIFO full blocks both ready and write.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef FIFO_ARB_BURST_EN
        beat_cnt_d  = beat_cnt_q;
`endif
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_din    = '0;
        grant_valid = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (any_valid) begin
                    state_d    = ST_XFER;
                    grant_id_d = pick_id;
`ifdef FIFO_ARB_BURST_EN
                    beat_cnt_d = '0;
`endif
                end
            end
            ST_XFER: begin
                grant_valid = 1'b1;
                if (!fifo_full) begin
                    req_ready = grant_onehot;
                end
                fifo_wr = sel_valid & ~fifo_full;
                if (fifo_wr) begin
                    fifo_din = sel_data;
                end
                if (!sel_valid) begin
                    // Producer withdrew: release so the next index gets first look.
                    state_d  = ST_ARB;
                    rr_ptr_d = next_ptr;
                end else if (fifo_wr) begin
                    if (last_beat) begin
                        state_d  = ST_ARB;
                        rr_ptr_d = next_ptr;
                    end
`ifdef FIFO_ARB_BURST_EN
                    beat_cnt_d = beat_cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State, grant and round-robin pointer registers; async reset aborts any grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ARB;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: vector table, hand sequences for reset, stall, release
// and bursts, then randomized traffic against a transaction-level model and scoreboard.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam int LIMIT = BL;
`else
    localparam int LIMIT = 1;
`endif

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_din;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .ID_W      (IW),
        .BURST_LEN (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] pdata [N];

    typedef struct {
        logic [N-1:0]  v;
        logic          f;
        logic          gv;
        logic [IW-1:0] gid;
        logic          wr;
        logic [N-1:0]  rdy;
    } vec_t;
    vec_t vecs[$];

    // reference model state
    bit m_busy;
    int m_gid;
    int m_ptr;
    int m_beats;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic f);
        req_valid = v;
        fifo_full = f;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdata[i];
    endtask

    task automatic next_cycle(input logic [N-1:0] v, input logic f);
        @(posedge clk);
        #1;
        drive(v, f);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic gv, input logic [IW-1:0] gid,
                              input logic wr, input logic [N-1:0] rdy, input logic [DW-1:0] din);
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
        chk({tag, ".grant_id"},    32'(grant_id),    32'(gid));
        chk({tag, ".fifo_wr"},     32'(fifo_wr),     32'(wr));
        chk({tag, ".req_ready"},   32'(req_ready),   32'(rdy));
        chk({tag, ".fifo_din"},    fifo_din,         din);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        m_busy  = 1'b0;
        m_gid   = 0;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    task automatic add(input logic [N-1:0] v, input logic f, input logic gv,
                       input logic [IW-1:0] gid, input logic wr, input logic [N-1:0] rdy);
        vec_t e;
        e.v = v; e.f = f; e.gv = gv; e.gid = gid; e.wr = wr; e.rdy = rdy;
        vecs.push_back(e);
    endtask

    initial begin
        logic [N-1:0]  pv_vec;
        logic          f;
        logic          exp_gv, exp_wr;
        logic [N-1:0]  exp_rdy;
        logic [DW-1:0] exp_din;
        logic [N-1:0]  acc;
        bit            pv   [N];
        int            pseq [N];
        int            wr_cnt [N];
        int            id;

        rst = 1'b1;
        for (int i = 0; i < N; i++) pdata[i] = 32'hA500_0000 | i;
        drive(4'b1111, 1'b0);

        // reset holds everything quiet even with all producers requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs($sformatf("reset%0d", i), 1'b0, '0, 1'b0, '0, '0);
        end
        do_reset();

        // vector table
`ifdef FIFO_ARB_BURST_EN
        add(4'b1111, 0, 0, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 0, 1, 4'b0001);
        add(4'b1111, 0, 1, 0, 1, 4'b0001);
        add(4'b1111, 1, 1, 0, 0, 4'b0000);
        add(4'b1111, 1, 1, 0, 0, 4'b0000);
        add(4'b1111, 1, 1, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 0, 1, 4'b0001);
        add(4'b1111, 0, 1, 0, 1, 4'b0001);
        add(4'b1111, 0, 0, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 1, 1, 4'b0010);
`else
        add(4'b1111, 0, 0, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 0, 1, 4'b0001);
        add(4'b1111, 0, 0, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 1, 1, 4'b0010);
        add(4'b1111, 0, 0, 1, 0, 4'b0000);
        add(4'b1111, 0, 1, 2, 1, 4'b0100);
        add(4'b1111, 0, 0, 2, 0, 4'b0000);
        add(4'b1111, 0, 1, 3, 1, 4'b1000);
        add(4'b1111, 0, 0, 3, 0, 4'b0000);
        add(4'b1111, 0, 1, 0, 1, 4'b0001);
        add(4'b1111, 0, 0, 0, 0, 4'b0000);
        add(4'b1111, 1, 1, 1, 0, 4'b0000);
        add(4'b1111, 1, 1, 1, 0, 4'b0000);
        add(4'b1111, 1, 1, 1, 0, 4'b0000);
        add(4'b1111, 0, 1, 1, 1, 4'b0010);
        add(4'b1111, 0, 0, 1, 0, 4'b0000);
        add(4'b1111, 0, 1, 2, 1, 4'b0100);
`endif
        foreach (vecs[i]) begin
            next_cycle(vecs[i].v, vecs[i].f);
            check_outs($sformatf("vec%0d", i), vecs[i].gv, vecs[i].gid, vecs[i].wr,
                       vecs[i].rdy, vecs[i].wr ? pdata[vecs[i].gid] : '0);
        end

        // early release: producer 2 drops valid, next pick starts at index 3
        do_reset();
        next_cycle(4'b0100, 1'b0);
        chk("rel.arb_gv", 32'(grant_valid), 32'd0);
        for (int j = 0; j < ((LIMIT >= 3) ? 2 : 0); j++) begin
            next_cycle(4'b0100, 1'b0);
            check_outs($sformatf("rel.beat%0d", j), 1'b1, 2'd2, 1'b1, 4'b0100, pdata[2]);
        end
        next_cycle(4'b0000, 1'b0);
        check_outs("rel.drop", 1'b1, 2'd2, 1'b0, 4'b0100, '0);
        next_cycle(4'b1101, 1'b0);
        chk("rel.arb_after", 32'(grant_valid), 32'd0);
        next_cycle(4'b1101, 1'b0);
        check_outs("rel.next", 1'b1, 2'd3, 1'b1, 4'b1000, pdata[3]);

        // asynchronous reset in the middle of a stalled grant
        do_reset();
        next_cycle(4'b0010, 1'b0);
        next_cycle(4'b0010, 1'b1);
        chk("midrst.pre_gv", 32'(grant_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("midrst.now", 1'b0, '0, 1'b0, '0, '0);
        next_cycle(4'b0010, 1'b0);
        check_outs("midrst.hold", 1'b0, '0, 1'b0, '0, '0);
        do_reset();

`ifdef FIFO_ARB_BURST_EN
        // producer 1 streams 10 words: 4, gap, 4, gap, 2
        begin
            logic [14:0] wr_pat;
            logic [14:0] gv_pat;
            int          sent;
            wr_pat = 15'b001101111011110;
            gv_pat = 15'b011101111011110;
            sent   = 0;
            for (int c = 0; c < 15; c++) begin
                pdata[1] = 32'h0000_1000 + sent;
                next_cycle((sent < 10) ? 4'b0010 : 4'b0000, 1'b0);
                chk($sformatf("burst.c%0d.wr", c), 32'(fifo_wr), 32'(wr_pat[c]));
                chk($sformatf("burst.c%0d.gv", c), 32'(grant_valid), 32'(gv_pat[c]));
                if (fifo_wr) chk($sformatf("burst.c%0d.din", c), fifo_din, 32'h0000_1000 + sent);
                if (req_valid[1] && req_ready[1]) sent++;
            end
            chk("burst.sent", 32'(sent), 32'd10);
        end
        do_reset();
`endif

        // randomized traffic against model and per-producer ordering scoreboard
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pseq[i] = 0; wr_cnt[i] = 0;
        end
        acc = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    pv[i] = 1'b0;
                    pseq[i]++;
                end
                if (!pv[i]) pv[i] = ($urandom_range(0, 99) < 55);
                pdata[i]  = {8'(i), 24'(pseq[i])};
                pv_vec[i] = pv[i];
            end
            f = ($urandom_range(0, 99) < 30);
            drive(pv_vec, f);
            @(negedge clk);

            exp_gv  = m_busy;
            exp_wr  = m_busy && pv_vec[m_gid] && !f;
            exp_rdy = (m_busy && !f) ? (N'(1) << m_gid) : '0;
            exp_din = exp_wr ? pdata[m_gid] : '0;
            check_outs($sformatf("rnd%0d", cyc), exp_gv, IW'(m_gid), exp_wr, exp_rdy, exp_din);

            if (fifo_wr) begin
                chk($sformatf("rnd%0d.wr_while_full", cyc), 32'(fifo_full), 32'd0);
                id = int'(fifo_din[31:24]);
                chk($sformatf("rnd%0d.wr_id", cyc), 32'(id < N), 32'd1);
                if (id < N) begin
                    chk($sformatf("rnd%0d.order_p%0d", cyc, id), 32'(fifo_din[23:0]),
                        32'(24'(wr_cnt[id])));
                    wr_cnt[id]++;
                end
            end
            acc = req_valid & req_ready;

            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_busy && pv_vec[(m_ptr + k) % N]) begin
                        m_busy  = 1'b1;
                        m_gid   = (m_ptr + k) % N;
                        m_beats = 0;
                    end
                end
            end else if (!pv_vec[m_gid]) begin
                m_busy = 1'b0;
                m_ptr  = (m_gid + 1) % N;
            end else if (!f) begin
                m_beats++;
                if (m_beats == LIMIT) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_gid + 1) % N;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rnd.count_p%0d", i), 32'(wr_cnt[i]), 32'(pseq[i] + int'(acc[i])));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
